// File: rtl/cc_top.sv
// cc_top: direct-mapped read-only cache (512 lines x 64 B) between an AXI-style read port and
// memory, with tag/data kept in an external one-cycle-latency SRAM and an APB version register.
module cc_top (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         psel_i,
    input  logic         penable_i,
    input  logic [11:0]  paddr_i,
    input  logic         pwrite_i,
    input  logic [31:0]  pwdata_i,
    output logic         pready_o,
    output logic [31:0]  prdata_o,
    output logic         pslverr_o,
    input  logic [3:0]   inct_arid_i,
    input  logic [31:0]  inct_araddr_i,
    input  logic [3:0]   inct_arlen_i,
    input  logic [2:0]   inct_arsize_i,
    input  logic [1:0]   inct_arburst_i,
    input  logic         inct_arvalid_i,
    output logic         inct_arready_o,
    output logic [3:0]   inct_rid_o,
    output logic [63:0]  inct_rdata_o,
    output logic [1:0]   inct_rresp_o,
    output logic         inct_rlast_o,
    output logic         inct_rvalid_o,
    input  logic         inct_rready_i,
    output logic [3:0]   mem_arid_o,
    output logic [31:0]  mem_araddr_o,
    output logic [3:0]   mem_arlen_o,
    output logic [2:0]   mem_arsize_o,
    output logic [1:0]   mem_arburst_o,
    output logic         mem_arvalid_o,
    input  logic         mem_arready_i,
    input  logic [3:0]   mem_rid_i,
    input  logic [63:0]  mem_rdata_i,
    input  logic [1:0]   mem_rresp_i,
    input  logic         mem_rlast_i,
    input  logic         mem_rvalid_i,
    output logic         mem_rready_o,
    output logic         rden_o,
    output logic [8:0]   raddr_o,
    input  logic [17:0]  rdata_tag_i,
    input  logic [511:0] rdata_data_i,
    output logic         wren_o,
    output logic [8:0]   waddr_o,
    output logic [17:0]  wdata_tag_o,
    output logic [511:0] wdata_data_o
);

    localparam logic [31:0] IP_VERSION = 32'h0001_2024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TAG_CMP = 3'd1,
        HIT_RD  = 3'd2,
        MISS_AR = 3'd3,
        MISS_R  = 3'd4,
        FILL    = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [3:0]     id_q, id_d;
    logic [2:0]     beat_q, beat_d;
    logic [511:0]   line_q, line_d;
    logic [2:0]     word_s;
    logic           hit_s;
    logic           unused_inputs_s;

    // Critical word first: beat k of a burst always maps to line word (word0 + k) mod 8.
    assign word_s = addr_q[5:3] + beat_q;
    assign hit_s  = rdata_tag_i[17] & (rdata_tag_i[16:0] == addr_q[31:15]);

    assign pready_o  = 1'b1;
    assign pslverr_o = 1'b0;
    assign prdata_o  = (psel_i && !pwrite_i) ? IP_VERSION : 32'd0;

    assign unused_inputs_s = ^{penable_i, paddr_i, pwdata_i, inct_arlen_i, inct_arsize_i,
                               inct_arburst_i, mem_rid_i, addr_q[2:0]};

    // State register, request latches, beat counter and line assembly buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            id_q    <= 4'd0;
            beat_q  <= 3'd0;
            line_q  <= 512'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
        end
    end

    // Next-state logic, datapath updates and every handshake/SRAM output
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        id_d           = id_q;
        beat_d         = beat_q;
        line_d         = line_q;
        inct_arready_o = 1'b0;
        inct_rid_o     = id_q;
        inct_rdata_o   = 64'd0;
        inct_rresp_o   = 2'd0;
        inct_rlast_o   = 1'b0;
        inct_rvalid_o  = 1'b0;
        mem_arid_o     = 4'd0;
        mem_araddr_o   = 32'd0;
        mem_arlen_o    = 4'd0;
        mem_arsize_o   = 3'd0;
        mem_arburst_o  = 2'd0;
        mem_arvalid_o  = 1'b0;
        mem_rready_o   = 1'b0;
        rden_o         = 1'b0;
        raddr_o        = 9'd0;
        wren_o         = 1'b0;
        waddr_o        = 9'd0;
        wdata_tag_o    = 18'd0;
        wdata_data_o   = 512'd0;
        case (state_q)
            IDLE: begin
                inct_arready_o = 1'b1;
                if (inct_arvalid_i) begin
                    addr_d  = inct_araddr_i;
                    id_d    = inct_arid_i;
                    beat_d  = 3'd0;
                    rden_o  = 1'b1;
                    raddr_o = inct_araddr_i[14:6];
                    state_d = TAG_CMP;
                end else begin
                    state_d = IDLE;
                end
            end
            TAG_CMP: begin
                if (hit_s) begin
                    line_d  = rdata_data_i;
                    state_d = HIT_RD;
                end else begin
                    state_d = MISS_AR;
                end
            end
            HIT_RD: begin
                inct_rvalid_o = 1'b1;
                inct_rdata_o  = line_q[{word_s, 6'd0} +: 64];
                inct_rlast_o  = (beat_q == 3'd7);
                if (inct_rready_i) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HIT_RD;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            MISS_AR: begin
                mem_arvalid_o = 1'b1;
                mem_arid_o    = id_q;
                mem_araddr_o  = {addr_q[31:3], 3'b000};
                mem_arlen_o   = 4'd7;
                mem_arsize_o  = 3'd3;
                mem_arburst_o = 2'd2;
                if (mem_arready_i) begin
                    beat_d  = 3'd0;
                    state_d = MISS_R;
                end else begin
                    state_d = MISS_AR;
                end
            end
            MISS_R: begin
                // Memory beats are forwarded straight through while being collected into the line.
                mem_rready_o  = inct_rready_i;
                inct_rvalid_o = mem_rvalid_i;
                inct_rdata_o  = mem_rdata_i;
                inct_rlast_o  = mem_rlast_i;
                inct_rresp_o  = mem_rresp_i;
                if (mem_rvalid_i && inct_rready_i) begin
                    line_d[{word_s, 6'd0} +: 64] = mem_rdata_i;
                    beat_d = beat_q + 3'd1;
                    if (mem_rlast_i) begin
                        state_d = FILL;
                    end else begin
                        state_d = MISS_R;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            FILL: begin
                wren_o       = 1'b1;
                waddr_o      = addr_q[14:6];
                wdata_tag_o  = {1'b1, addr_q[31:15]};
                wdata_data_o = line_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cc_top.sv
// Self-checking bench for cc_top: SRAM and memory-slave models, a flat 64 KB memory image and a
// line/tag model of the cache predict hit/miss, every returned beat and every refill write.
module tb_cc_top;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
    logic [11:0]  paddr_i = 12'd0;
    logic [31:0]  pwdata_i = 32'd0;
    logic         pready_o, pslverr_o;
    logic [31:0]  prdata_o;
    logic [3:0]   inct_arid_i = 4'd0, inct_arlen_i = 4'd0;
    logic [31:0]  inct_araddr_i = 32'd0;
    logic [2:0]   inct_arsize_i = 3'd0;
    logic [1:0]   inct_arburst_i = 2'd0;
    logic         inct_arvalid_i = 1'b0, inct_rready_i = 1'b0;
    logic         inct_arready_o, inct_rlast_o, inct_rvalid_o;
    logic [3:0]   inct_rid_o;
    logic [63:0]  inct_rdata_o;
    logic [1:0]   inct_rresp_o;
    logic [3:0]   mem_arid_o, mem_arlen_o;
    logic [31:0]  mem_araddr_o;
    logic [2:0]   mem_arsize_o;
    logic [1:0]   mem_arburst_o;
    logic         mem_arvalid_o, mem_rready_o;
    logic         mem_arready_i = 1'b0, mem_rlast_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [3:0]   mem_rid_i = 4'd0;
    logic [63:0]  mem_rdata_i = 64'd0;
    logic [1:0]   mem_rresp_i = 2'd0;
    logic         rden_o, wren_o;
    logic [8:0]   raddr_o, waddr_o;
    logic [17:0]  rdata_tag_i = 18'd0, wdata_tag_o;
    logic [511:0] rdata_data_i = 512'd0, wdata_data_o;

    cc_top dut (
        .clk(clk), .rst_n(rst_n),
        .psel_i(psel_i), .penable_i(penable_i), .paddr_i(paddr_i), .pwrite_i(pwrite_i),
        .pwdata_i(pwdata_i), .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
        .inct_arid_i(inct_arid_i), .inct_araddr_i(inct_araddr_i), .inct_arlen_i(inct_arlen_i),
        .inct_arsize_i(inct_arsize_i), .inct_arburst_i(inct_arburst_i),
        .inct_arvalid_i(inct_arvalid_i), .inct_arready_o(inct_arready_o),
        .inct_rid_o(inct_rid_o), .inct_rdata_o(inct_rdata_o), .inct_rresp_o(inct_rresp_o),
        .inct_rlast_o(inct_rlast_o), .inct_rvalid_o(inct_rvalid_o), .inct_rready_i(inct_rready_i),
        .mem_arid_o(mem_arid_o), .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o),
        .mem_arsize_o(mem_arsize_o), .mem_arburst_o(mem_arburst_o),
        .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
        .mem_rid_i(mem_rid_i), .mem_rdata_i(mem_rdata_i), .mem_rresp_i(mem_rresp_i),
        .mem_rlast_i(mem_rlast_i), .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
        .rden_o(rden_o), .raddr_o(raddr_o), .rdata_tag_i(rdata_tag_i),
        .rdata_data_i(rdata_data_i), .wren_o(wren_o), .waddr_o(waddr_o),
        .wdata_tag_o(wdata_tag_o), .wdata_data_o(wdata_data_o)
    );

    always #5 clk = ~clk;

    logic [63:0]  mem_q [0:8191];
    logic [17:0]  sram_tag [0:511] = '{default: 18'd0};
    logic [511:0] sram_data [0:511] = '{default: 512'd0};
    bit           mdl_valid [0:511];
    logic [16:0]  mdl_tag [0:511];

    int           mem_ar_cnt = 0, wr_cnt = 0;
    logic [31:0]  last_ar_addr = 32'd0;
    logic [3:0]   last_ar_id = 4'd0, last_ar_len = 4'd0;
    logic [2:0]   last_ar_size = 3'd0;
    logic [1:0]   last_ar_burst = 2'd0;
    logic [8:0]   last_waddr = 9'd0;
    logic [17:0]  last_wtag = 18'd0;
    logic [511:0] last_wdata = 512'd0;

    int           total = 0, bad = 0;
    int           wr0_g;
    bit           miss_g;

    // SRAM and memory-slave models: act just after negedge, sample handshakes 2 ns later.
    bit           ar_hs_f = 1'b0, r_hs_f = 1'b0, rd_f = 1'b0, wr_f = 1'b0, s_busy = 1'b0;
    logic [8:0]   ra_f = 9'd0, wa_f = 9'd0;
    logic [17:0]  wt_f = 18'd0;
    logic [511:0] wd_f = 512'd0;
    logic [31:0]  s_addr = 32'd0;
    logic [3:0]   s_id = 4'd0;
    logic [12:0]  s_widx = 13'd0;
    int           s_k = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_arready_i = 1'b0;
            mem_rvalid_i  = 1'b0;
            mem_rlast_i   = 1'b0;
            rdata_tag_i   = 18'd0;
            rdata_data_i  = 512'd0;
            s_busy = 1'b0; ar_hs_f = 1'b0; r_hs_f = 1'b0; rd_f = 1'b0; wr_f = 1'b0;
        end else begin
            if (wr_f) begin
                sram_tag[wa_f]  = wt_f;
                sram_data[wa_f] = wd_f;
            end
            if (rd_f) begin
                rdata_tag_i  = sram_tag[ra_f];
                rdata_data_i = sram_data[ra_f];
            end
            if (r_hs_f) begin
                mem_rvalid_i = 1'b0;
                mem_rlast_i  = 1'b0;
                s_k++;
                if (s_k == 8) s_busy = 1'b0;
            end
            if (ar_hs_f) begin
                s_busy = 1'b1;
                s_k    = 0;
                s_addr = last_ar_addr;
                s_id   = last_ar_id;
            end
            mem_arready_i = !s_busy && ($urandom_range(0, 3) != 0);
            if (s_busy && !mem_rvalid_i && ($urandom_range(0, 7) != 0)) begin
                s_widx       = {s_addr[15:6], 3'(s_addr[5:3] + s_k[2:0])};
                mem_rdata_i  = mem_q[s_widx];
                mem_rresp_i  = s_widx[1:0];
                mem_rlast_i  = (s_k == 7);
                mem_rid_i    = s_id;
                mem_rvalid_i = 1'b1;
            end
        end
        #2;
        ar_hs_f = mem_arvalid_o && mem_arready_i;
        if (ar_hs_f) begin
            mem_ar_cnt++;
            last_ar_addr  = mem_araddr_o;
            last_ar_id    = mem_arid_o;
            last_ar_len   = mem_arlen_o;
            last_ar_size  = mem_arsize_o;
            last_ar_burst = mem_arburst_o;
        end
        r_hs_f = mem_rvalid_i && mem_rready_o;
        rd_f   = rden_o;
        ra_f   = raddr_o;
        wr_f   = wren_o;
        wa_f   = waddr_o;
        wt_f   = wdata_tag_o;
        wd_f   = wdata_data_o;
        if (wr_f) begin
            wr_cnt++;
            last_waddr = waddr_o;
            last_wtag  = wdata_tag_o;
            last_wdata = wdata_data_o;
        end
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One read transaction; hit/miss and every beat are predicted from the cache and memory models.
    task automatic do_read(input logic [31:0] a, input logic [3:0] id, input int stall_beat,
                           output bit was_miss);
        logic [8:0]   idx;
        bit           miss, prev_stalled;
        int           ar0, wr0, k, cyc, first, stall_cnt, n;
        logic [63:0]  prev_data;
        logic         prev_last;
        logic [12:0]  widx;
        logic [511:0] exp_line;
        idx  = a[14:6];
        miss = !(mdl_valid[idx] && (mdl_tag[idx] == a[31:15]));
        ar0 = mem_ar_cnt; wr0 = wr_cnt;
        k = 0; first = -1; stall_cnt = 0; prev_stalled = 1'b0; prev_data = 64'd0; prev_last = 1'b0;
        @(negedge clk);
        inct_araddr_i  = a;
        inct_arid_i    = id;
        inct_arlen_i   = 4'($urandom);
        inct_arsize_i  = 3'($urandom);
        inct_arburst_i = 2'($urandom);
        inct_arvalid_i = 1'b1;
        #1;
        n = 0;
        while (!inct_arready_o && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("ar_ready", 512'(inct_arready_o), 512'd1);
        chk("sram_rden", 512'(rden_o), 512'd1);
        chk("sram_raddr", 512'(raddr_o), 512'(idx));
        @(negedge clk);
        inct_arvalid_i = 1'b0;
        inct_araddr_i  = $urandom;
        cyc = 1;
        while (k < 8 && cyc < 500) begin
            inct_rready_i = (k == stall_beat && stall_cnt < 5) ? 1'b0 : ($urandom_range(0, 7) != 0);
            #1;
            if (prev_stalled) begin
                chk("hold_valid", 512'(inct_rvalid_o), 512'd1);
                chk("hold_data", 512'(inct_rdata_o), 512'(prev_data));
                chk("hold_last", 512'(inct_rlast_o), 512'(prev_last));
            end
            if (inct_rvalid_o) begin
                if (first < 0) first = cyc;
                if (inct_rready_i) begin
                    widx = {a[15:6], 3'(a[5:3] + k[2:0])};
                    chk("beat_data", 512'(inct_rdata_o), 512'(mem_q[widx]));
                    chk("beat_last", 512'(inct_rlast_o), 512'(k == 7));
                    chk("beat_rid", 512'(inct_rid_o), 512'(id));
                    chk("beat_resp", 512'(inct_rresp_o), 512'(miss ? widx[1:0] : 2'd0));
                    k++;
                    prev_stalled = 1'b0;
                end else begin
                    prev_stalled = 1'b1;
                    prev_data    = inct_rdata_o;
                    prev_last    = inct_rlast_o;
                    if (k == stall_beat) stall_cnt++;
                    chk("stall_mem_rready", 512'(mem_rready_o), 512'd0);
                end
            end else begin
                prev_stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        inct_rready_i = 1'b0;
        chk("beat_count", 512'(k), 512'd8);
        if (!miss) chk("hit_latency", 512'(first), 512'd2);
        #1;
        n = 0;
        while (!inct_arready_o && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("back_to_idle", 512'(inct_arready_o), 512'd1);
        chk("mem_ar_count", 512'(mem_ar_cnt - ar0), 512'(miss));
        chk("fill_count", 512'(wr_cnt - wr0), 512'(miss));
        if (miss) begin
            for (int w = 0; w < 8; w++) exp_line[w*64 +: 64] = mem_q[{a[15:6], 3'(w)}];
            chk("mem_araddr", 512'(last_ar_addr), 512'({a[31:3], 3'b000}));
            chk("mem_arid", 512'(last_ar_id), 512'(id));
            chk("mem_arlen", 512'(last_ar_len), 512'd7);
            chk("mem_arsize", 512'(last_ar_size), 512'd3);
            chk("mem_arburst", 512'(last_ar_burst), 512'd2);
            chk("fill_waddr", 512'(last_waddr), 512'(idx));
            chk("fill_wtag", 512'(last_wtag), 512'({1'b1, a[31:15]}));
            chk("fill_wdata", last_wdata, exp_line);
            mdl_valid[idx] = 1'b1;
            mdl_tag[idx]   = a[31:15];
        end
        was_miss = (mem_ar_cnt != ar0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        logic [8:0]  ridx;
        logic [31:0] ra;
        int          n;
        for (int i = 0; i < 8192; i++) mem_q[i] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rvalid", 512'(inct_rvalid_o), 512'd0);
        chk("rst_rlast", 512'(inct_rlast_o), 512'd0);
        chk("rst_rdata", 512'(inct_rdata_o), 512'd0);
        chk("rst_mem_arvalid", 512'(mem_arvalid_o), 512'd0);
        chk("rst_mem_araddr", 512'(mem_araddr_o), 512'd0);
        chk("rst_mem_rready", 512'(mem_rready_o), 512'd0);
        chk("rst_rden", 512'(rden_o), 512'd0);
        chk("rst_wren", 512'(wren_o), 512'd0);
        chk("rst_wdata", wdata_data_o, 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arready_after_reset", 512'(inct_arready_o), 512'd1);

        @(negedge clk);
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 12'h024; pwrite_i = 1'b0;
        @(negedge clk);
        penable_i = 1'b1;
        #1;
        chk("apb_prdata", 512'(prdata_o), 512'h0001_2024);
        chk("apb_pready", 512'(pready_o), 512'd1);
        chk("apb_pslverr", 512'(pslverr_o), 512'd0);
        @(negedge clk);
        pwrite_i = 1'b1; pwdata_i = 32'hDEAD_BEEF;
        #1;
        chk("apb_wr_pready", 512'(pready_o), 512'd1);
        chk("apb_wr_pslverr", 512'(pslverr_o), 512'd0);
        @(negedge clk);
        pwrite_i = 1'b0; paddr_i = 12'h000;
        #1;
        chk("apb_prdata_after_write", 512'(prdata_o), 512'h0001_2024);
        @(negedge clk);
        psel_i = 1'b0; penable_i = 1'b0;

        do_read(32'h0000_1240, 4'h5, 99, miss_g);
        chk("first_access_miss", 512'(miss_g), 512'd1);
        do_read(32'h0000_1258, 4'h3, 3, miss_g);
        chk("same_line_hit", 512'(miss_g), 512'd0);
        do_read(32'h0000_9240, 4'hA, 2, miss_g);
        chk("new_tag_miss", 512'(miss_g), 512'd1);
        do_read(32'h0000_1240, 4'h6, 5, miss_g);
        chk("evicted_line_miss", 512'(miss_g), 512'd1);

        // Reset in the middle of a refill: no SRAM write, the line stays uncached.
        @(negedge clk);
        inct_araddr_i = 32'h0000_3000; inct_arid_i = 4'h2; inct_arvalid_i = 1'b1; inct_rready_i = 1'b1;
        @(negedge clk);
        inct_arvalid_i = 1'b0;
        repeat (6) @(negedge clk);
        wr0_g = wr_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", 512'(inct_rvalid_o), 512'd0);
        chk("midrst_mem_arvalid", 512'(mem_arvalid_o), 512'd0);
        chk("midrst_mem_rready", 512'(mem_rready_o), 512'd0);
        chk("midrst_wren", 512'(wren_o), 512'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        inct_rready_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_no_fill", 512'(wr_cnt - wr0_g), 512'd0);
        chk("midrst_arready", 512'(inct_arready_o), 512'd1);
        chk("midrst_rid_cleared", 512'(inct_rid_o), 512'd0);
        do_read(32'h0000_3000, 4'h2, 99, miss_g);
        chk("abandoned_line_miss", 512'(miss_g), 512'd1);

        for (int t = 0; t < 800; t++) begin
            ra = {16'd0, 10'($urandom_range(0, 1023)), 6'd0};
            do_read(ra, 4'($urandom), $urandom_range(0, 15), miss_g);
        end
        for (int t = 0; t < 800; t++) begin
            ridx = 9'($urandom_range(0, 511));
            n = 0;
            while (!mdl_valid[ridx] && n < 600) begin
                ridx = ridx + 9'd1;
                n++;
            end
            ra = {mdl_tag[ridx], ridx, 3'($urandom_range(0, 7)), 3'd0};
            do_read(ra, 4'($urandom), $urandom_range(0, 15), miss_g);
            chk("random_hit", 512'(miss_g), 512'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
